// File: rtl/pipe_dif.sv
// Pipelined WIDTH-bit subtractor with valid/ready handshake. Each stage resolves one
// WIDTH/STAGES-bit chunk, rippling the borrow through registers, then applies wrap/saturate.
module pipe_dif #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [1:0]       i_mode,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   output logic [WIDTH-1:0] o_rez,
   output logic             o_borrow,
   output logic             o_ovf,
   output logic             o_zero,
   output logic             o_out_valid,
   input  logic             i_out_ready
);

   localparam int CW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic [STAGES-1:0]            r_vld;
   logic [STAGES-1:0]            r_br;
   logic [STAGES-1:0][1:0]       r_mode;
   logic [STAGES-1:0][WIDTH-1:0] r_a;
   logic [STAGES-1:0][WIDTH-1:0] r_b;
   logic [STAGES-1:0][WIDTH-1:0] r_d;

   logic [STAGES:0]              w_prevVld;
   logic [STAGES:0]              w_prevBr;
   logic [STAGES:0][1:0]         w_prevMode;
   logic [STAGES:0][WIDTH-1:0]   w_prevA;
   logic [STAGES:0][WIDTH-1:0]   w_prevB;
   logic [STAGES:0][WIDTH-1:0]   w_prevD;
   logic [STAGES-1:0][CW:0]      w_sub;
   logic [STAGES-1:0][WIDTH-1:0] w_nxtD;
   logic                         w_adv;
   logic [WIDTH-1:0]             w_raw;
   logic                         w_aMsb;
   logic                         w_bMsb;
   logic                         w_unused;

   // Index k of each w_prev* vector is what feeds stage k: the port for k = 0, else stage k-1.
   assign w_prevVld  = {r_vld, i_in_valid};
   assign w_prevBr   = {r_br, 1'b0};
   assign w_prevMode = {r_mode, i_mode};
   assign w_prevA    = {r_a, i_a};
   assign w_prevB    = {r_b, i_b};
   assign w_prevD    = {r_d, {WIDTH{1'b0}}};

   assign w_unused = ^{w_prevVld[STAGES], w_prevBr[STAGES], w_prevMode[STAGES],
                       w_prevA[STAGES], w_prevB[STAGES], w_prevD[STAGES]};

   assign w_adv      = !r_vld[LAST] || i_out_ready;
   assign o_in_ready = w_adv;

   always_comb begin
      w_sub  = '0;
      w_nxtD = '0;
      for (int k = 0; k < STAGES; k++) begin
         w_sub[k] = {1'b0, w_prevA[k][k*CW +: CW]} - {1'b0, w_prevB[k][k*CW +: CW]}
                    - {{CW{1'b0}}, w_prevBr[k]};
         w_nxtD[k] = w_prevD[k];
         w_nxtD[k][k*CW +: CW] = w_sub[k][CW-1:0];
      end
   end

   // All stages move together; operands and mode travel with the partial result.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_vld  <= '0;
         r_br   <= '0;
         r_mode <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_d    <= '0;
      end else if (w_adv) begin
         r_vld  <= w_prevVld[STAGES-1:0];
         r_mode <= w_prevMode[STAGES-1:0];
         r_a    <= w_prevA[STAGES-1:0];
         r_b    <= w_prevB[STAGES-1:0];
         r_d    <= w_nxtD;
         for (int k = 0; k < STAGES; k++) begin
            r_br[k] <= w_sub[k][CW];
         end
      end
   end

   assign w_raw       = r_d[LAST];
   assign w_aMsb      = r_a[LAST][WIDTH-1];
   assign w_bMsb      = r_b[LAST][WIDTH-1];
   assign o_borrow    = r_br[LAST];
   assign o_ovf       = (w_aMsb != w_bMsb) && (w_raw[WIDTH-1] != w_aMsb);
   assign o_out_valid = r_vld[LAST];

   always_comb begin
      o_rez = w_raw;
      case (r_mode[LAST])
         2'b01: begin
            if (o_ovf) begin
               o_rez = w_aMsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
         end
         2'b10: begin
            if (o_borrow) begin
               o_rez = '0;
            end
         end
         default: o_rez = w_raw;
      endcase
   end

   assign o_zero = (o_rez == '0);

endmodule

// File: tb/tb_pipe_dif.sv
// Scoreboard bench for pipe_dif: three instances (8b/2 stages, 8b/1 stage, 16b/4 stages)
// driven in turn with directed vectors; a negedge monitor checks every presented result.
module tb_pipe_dif;

   typedef struct packed {
      logic [15:0] rez;
      logic        brw;
      logic        ovf;
      logic        zro;
   } exp_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  m;
      exp_t        e;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] a    [3];
   logic [15:0] b    [3];
   logic [1:0]  mode [3];
   logic        inV  [3];
   logic        outR [3];
   logic        inR  [3];
   logic        outV [3];
   logic        brw  [3];
   logic        ovf  [3];
   logic        zro  [3];
   logic [7:0]  rez0;
   logic [7:0]  rez1;
   logic [15:0] rez2;
   logic [15:0] rezW [3];

   int   total = 0;
   int   bad   = 0;
   int   stg [3] = '{2, 1, 4};
   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];
   vec_t v8  [12];
   vec_t v16 [12];
   vec_t s8  [6];
   vec_t s16 [6];
   vec_t r8  [3];
   vec_t r16 [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      rezW[0] = {8'h00, rez0};
      rezW[1] = {8'h00, rez1};
      rezW[2] = rez2;
   end

   pipe_dif #(.WIDTH(8), .STAGES(2)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_a(a[0][7:0]), .i_b(b[0][7:0]), .i_mode(mode[0]),
      .i_in_valid(inV[0]), .o_in_ready(inR[0]), .o_rez(rez0), .o_borrow(brw[0]),
      .o_ovf(ovf[0]), .o_zero(zro[0]), .o_out_valid(outV[0]), .i_out_ready(outR[0]));

   pipe_dif #(.WIDTH(8), .STAGES(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_a(a[1][7:0]), .i_b(b[1][7:0]), .i_mode(mode[1]),
      .i_in_valid(inV[1]), .o_in_ready(inR[1]), .o_rez(rez1), .o_borrow(brw[1]),
      .o_ovf(ovf[1]), .o_zero(zro[1]), .o_out_valid(outV[1]), .i_out_ready(outR[1]));

   pipe_dif #(.WIDTH(16), .STAGES(4)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_a(a[2]), .i_b(b[2]), .i_mode(mode[2]),
      .i_in_valid(inV[2]), .o_in_ready(inR[2]), .o_rez(rez2), .o_borrow(brw[2]),
      .o_ovf(ovf[2]), .o_zero(zro[2]), .o_out_valid(outV[2]), .i_out_ready(outR[2]));

   function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb,
                               input logic [1:0] vm, input logic [15:0] er,
                               input logic eb, input logic eo, input logic ez);
      vec_t v;
      v.a     = va;
      v.b     = vb;
      v.m     = vm;
      v.e.rez = er;
      v.e.brw = eb;
      v.e.ovf = eo;
      v.e.zro = ez;
      return v;
   endfunction

   function automatic vec_t pick(input int d, input int set, input int i);
      vec_t v;
      case (set)
         0:       v = (d == 2) ? v16[i] : v8[i];
         1:       v = (d == 2) ? s16[i] : s8[i];
         default: v = (d == 2) ? r16[i] : r8[i];
      endcase
      return v;
   endfunction

   function automatic int qsize(input int d);
      case (d)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic pushExp(input int d, input exp_t e);
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic clearExp(input int d);
      case (d)
         0:       q0.delete();
         1:       q1.delete();
         default: q2.delete();
      endcase
   endtask

   task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Compares the presented result with the queue head; pops only on an actual transfer.
   task automatic checkOutput(input int d);
      exp_t e;
      exp_t got;
      logic have;
      have = 1'b0;
      e    = '0;
      got  = {rezW[d], brw[d], ovf[d], zro[d]};
      if (qsize(d) > 0) begin
         have = 1'b1;
         case (d)
            0:       e = q0[0];
            1:       e = q1[0];
            default: e = q2[0];
         endcase
      end
      total++;
      if (!have) begin
         bad++;
         $display("[TB] FAIL out%0d_unexpected: got rez=%h brw=%b ovf=%b zero=%b, want no output",
                  d, got.rez, got.brw, got.ovf, got.zro);
      end else if (got !== e) begin
         bad++;
         $display("[TB] FAIL out%0d_result: got rez=%h brw=%b ovf=%b zero=%b, want rez=%h brw=%b ovf=%b zero=%b",
                  d, got.rez, got.brw, got.ovf, got.zro, e.rez, e.brw, e.ovf, e.zro);
      end
      if (have && outR[d]) begin
         case (d)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
         endcase
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int d = 0; d < 3; d++) begin
            if (outV[d] === 1'b1) checkOutput(d);
         end
      end
   end

   task automatic applyStimulus(input int d, input vec_t v);
      logic took;
      took = 1'b0;
      for (int n = 0; n < 20 && !took; n++) begin
         a[d]    = v.a;
         b[d]    = v.b;
         mode[d] = v.m;
         inV[d]  = 1'b1;
         outR[d] = 1'b1;
         #1;
         took = inR[d];
         if (took) pushExp(d, v.e);
         @(posedge clk);
         #1;
      end
      inV[d] = 1'b0;
      if (!took) begin
         total++;
         bad++;
         $display("[TB] FAIL accept%0d: got no transfer in 20 cycles, want one", d);
      end
   endtask

   task automatic waitDrain(input int d, input string tag);
      outR[d] = 1'b1;
      for (int n = 0; n < 40 && qsize(d) != 0; n++) begin
         @(posedge clk);
         #1;
      end
      checkVal($sformatf("%s_pending%0d", tag, d), 16'(qsize(d)), 16'd0);
   endtask

   task automatic runDut(input int d);
      vec_t v;
      int   cnt;
      int   idx;
      logic ordy;

      // Latency from an empty pipeline with the consumer always ready
      applyStimulus(d, pick(d, 0, 0));
      cnt = 1;
      while (outV[d] !== 1'b1 && cnt < 10) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      checkVal($sformatf("latency%0d", d), 16'(cnt), 16'(stg[d]));
      for (int i = 1; i < 12; i++) applyStimulus(d, pick(d, 0, i));
      waitDrain(d, "vectors");

      // Back-to-back stream with the consumer stalled for three cycles
      idx = 0;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         v       = pick(d, 1, idx);
         ordy    = !(c >= 3 && c < 6);
         a[d]    = v.a;
         b[d]    = v.b;
         mode[d] = v.m;
         inV[d]  = 1'b1;
         outR[d] = ordy;
         #1;
         if (c == 4 || c == 5) begin
            checkVal($sformatf("stall_inready%0d_c%0d", d, c), 16'(inR[d]), 16'd0);
            checkVal($sformatf("stall_valid%0d_c%0d", d, c), 16'(outV[d]), 16'd1);
         end
         if (inR[d]) begin
            pushExp(d, v.e);
            idx++;
         end
         @(posedge clk);
         #1;
      end
      inV[d]  = 1'b0;
      outR[d] = 1'b1;
      checkVal($sformatf("stream_accepted%0d", d), 16'(idx), 16'd6);
      waitDrain(d, "stream");

      // One-cycle reset while two results are in flight
      applyStimulus(d, pick(d, 2, 0));
      applyStimulus(d, pick(d, 2, 1));
      rst_n = 1'b0;
      clearExp(d);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkVal($sformatf("flush_valid%0d", d), 16'(outV[d]), 16'd0);
      checkVal($sformatf("flush_rez%0d", d), rezW[d], 16'd0);
      checkVal($sformatf("flush_zero%0d", d), 16'(zro[d]), 16'd1);
      checkVal($sformatf("flush_inready%0d", d), 16'(inR[d]), 16'd1);
      repeat (6) @(posedge clk);
      #1;
      applyStimulus(d, pick(d, 2, 2));
      waitDrain(d, "postreset");
   endtask

   initial begin
      v8[0]  = mk(16'h35, 16'h12, 2'b00, 16'h23, 1'b0, 1'b0, 1'b0);
      v8[1]  = mk(16'h10, 16'h01, 2'b00, 16'h0F, 1'b0, 1'b0, 1'b0);
      v8[2]  = mk(16'h00, 16'h01, 2'b00, 16'hFF, 1'b1, 1'b0, 1'b0);
      v8[3]  = mk(16'h80, 16'h01, 2'b00, 16'h7F, 1'b0, 1'b1, 1'b0);
      v8[4]  = mk(16'h80, 16'h01, 2'b01, 16'h80, 1'b0, 1'b1, 1'b0);
      v8[5]  = mk(16'h80, 16'h01, 2'b10, 16'h7F, 1'b0, 1'b1, 1'b0);
      v8[6]  = mk(16'h7F, 16'hFF, 2'b01, 16'h7F, 1'b1, 1'b1, 1'b0);
      v8[7]  = mk(16'h05, 16'h07, 2'b10, 16'h00, 1'b1, 1'b0, 1'b1);
      v8[8]  = mk(16'h42, 16'h42, 2'b00, 16'h00, 1'b0, 1'b0, 1'b1);
      v8[9]  = mk(16'h05, 16'h07, 2'b11, 16'hFE, 1'b1, 1'b0, 1'b0);
      v8[10] = mk(16'h7F, 16'hFF, 2'b00, 16'h80, 1'b1, 1'b1, 1'b0);
      v8[11] = mk(16'h00, 16'h80, 2'b01, 16'h7F, 1'b1, 1'b1, 1'b0);

      v16[0]  = mk(16'h1235, 16'h0012, 2'b00, 16'h1223, 1'b0, 1'b0, 1'b0);
      v16[1]  = mk(16'h1000, 16'h0001, 2'b00, 16'h0FFF, 1'b0, 1'b0, 1'b0);
      v16[2]  = mk(16'h0000, 16'h0001, 2'b00, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      v16[3]  = mk(16'h8000, 16'h0001, 2'b00, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      v16[4]  = mk(16'h8000, 16'h0001, 2'b01, 16'h8000, 1'b0, 1'b1, 1'b0);
      v16[5]  = mk(16'h8000, 16'h0001, 2'b10, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      v16[6]  = mk(16'h7FFF, 16'hFFFF, 2'b01, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      v16[7]  = mk(16'h0005, 16'h0007, 2'b10, 16'h0000, 1'b1, 1'b0, 1'b1);
      v16[8]  = mk(16'h4242, 16'h4242, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1);
      v16[9]  = mk(16'h0005, 16'h0007, 2'b11, 16'hFFFE, 1'b1, 1'b0, 1'b0);
      v16[10] = mk(16'h7FFF, 16'hFFFF, 2'b00, 16'h8000, 1'b1, 1'b1, 1'b0);
      v16[11] = mk(16'h0000, 16'h8000, 2'b01, 16'h7FFF, 1'b1, 1'b1, 1'b0);

      s8[0] = mk(16'h11, 16'h01, 2'b00, 16'h10, 1'b0, 1'b0, 1'b0);
      s8[1] = mk(16'h20, 16'h30, 2'b00, 16'hF0, 1'b1, 1'b0, 1'b0);
      s8[2] = mk(16'hFF, 16'hFF, 2'b00, 16'h00, 1'b0, 1'b0, 1'b1);
      s8[3] = mk(16'h90, 16'h10, 2'b10, 16'h80, 1'b0, 1'b0, 1'b0);
      s8[4] = mk(16'h01, 16'h02, 2'b10, 16'h00, 1'b1, 1'b0, 1'b1);
      s8[5] = mk(16'hA0, 16'h50, 2'b01, 16'h80, 1'b0, 1'b1, 1'b0);

      s16[0] = mk(16'h1100, 16'h0001, 2'b00, 16'h10FF, 1'b0, 1'b0, 1'b0);
      s16[1] = mk(16'h2000, 16'h3000, 2'b00, 16'hF000, 1'b1, 1'b0, 1'b0);
      s16[2] = mk(16'hFFFF, 16'hFFFF, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1);
      s16[3] = mk(16'h9000, 16'h1000, 2'b10, 16'h8000, 1'b0, 1'b0, 1'b0);
      s16[4] = mk(16'h0001, 16'h0002, 2'b10, 16'h0000, 1'b1, 1'b0, 1'b1);
      s16[5] = mk(16'hA000, 16'h5000, 2'b01, 16'h8000, 1'b0, 1'b1, 1'b0);

      r8[0]  = mk(16'h12, 16'h34, 2'b00, 16'hDE, 1'b1, 1'b0, 1'b0);
      r8[1]  = mk(16'h56, 16'h78, 2'b00, 16'hDE, 1'b1, 1'b0, 1'b0);
      r8[2]  = mk(16'h9A, 16'h0A, 2'b00, 16'h90, 1'b0, 1'b0, 1'b0);
      r16[0] = mk(16'h1234, 16'h5678, 2'b00, 16'hBBBC, 1'b1, 1'b0, 1'b0);
      r16[1] = mk(16'h5678, 16'h9ABC, 2'b00, 16'hBBBC, 1'b1, 1'b1, 1'b0);
      r16[2] = mk(16'h9A00, 16'h0A00, 2'b00, 16'h9000, 1'b0, 1'b0, 1'b0);

      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         a[d]    = '0;
         b[d]    = '0;
         mode[d] = '0;
         inV[d]  = 1'b0;
         outR[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checkVal($sformatf("rst_valid%0d", d), 16'(outV[d]), 16'd0);
         checkVal($sformatf("rst_rez%0d", d), rezW[d], 16'd0);
         checkVal($sformatf("rst_borrow%0d", d), 16'(brw[d]), 16'd0);
         checkVal($sformatf("rst_ovf%0d", d), 16'(ovf[d]), 16'd0);
         checkVal($sformatf("rst_zero%0d", d), 16'(zro[d]), 16'd1);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checkVal($sformatf("release_inready%0d", d), 16'(inR[d]), 16'd1);
         outR[d] = 1'b1;
      end

      for (int d = 0; d < 3; d++) runDut(d);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      bad++;
      $display("[TB] FAIL watchdog: got no completion by 100000, want completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_dif.md
PIPE_DIF -- requirements
Module: pipe_dif

Interface
REQ-001 Parameter WIDTH, default 8, is the operand and result width in bits; legal values are 2..64.
REQ-002 Parameter STAGES, default 2, is the pipeline depth in cycles; legal values are 1..4, and WIDTH SHALL be divisible by STAGES.
REQ-003 clk  in  1  is the single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  is the reset: synchronous, active-low.
REQ-005 a  in  WIDTH  is the minuend.
REQ-006 b  in  WIDTH  is the subtrahend.
REQ-007 mode  in  2  selects the result mode: 00 wrap, 01 signed saturate, 10 unsigned saturate, 11 treated as 00.
REQ-008 in_valid  in  1  means a, b and mode are valid this cycle.
REQ-009 in_ready  out  1  means the block accepts input this cycle.
REQ-010 rez  out  WIDTH  is the result.
REQ-011 borrow  out  1  is the unsigned borrow out of the MSB (set when a < b unsigned).
REQ-012 ovf  out  1  is signed overflow of the true difference.
REQ-013 zero  out  1  is set when rez == 0 after mode processing.
REQ-014 out_valid  out  1  means rez and the flags are valid.
REQ-015 out_ready  in  1  means the consumer takes the output this cycle.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-017 Pipeline advance condition: adv = !out_valid || out_ready; in_ready SHALL equal adv, combinationally.
REQ-018 On adv, every stage SHALL shift by one position together with its valid bit; when adv is 0, all stages SHALL hold.
REQ-019 Bubbles (in_valid = 0 while adv = 1) SHALL propagate as invalid stages; bubbles are not compressed.
REQ-020 Latency: an accepted operand pair SHALL appear at out_valid exactly STAGES cycles later when no stall occurs; each stalled cycle adds exactly one cycle.
REQ-021 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-022 Operands are split into STAGES chunks of WIDTH/STAGES bits, LSB chunk first.
REQ-023 Stage k SHALL compute chunk k as a - b - borrow_in, where borrow_in is 0 for k = 0 and is otherwise the registered borrow from stage k-1.
REQ-024 Unprocessed operand chunks and the mode SHALL be skew-delayed alongside the data, so that the final rez equals the full WIDTH-bit difference.
REQ-025 The raw difference SHALL be (a - b) mod 2^WIDTH.
REQ-026 borrow SHALL be the borrow out of the top chunk.
REQ-027 ovf SHALL be computed as (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]).
REQ-028 In mode 01 with ovf = 1, rez SHALL be 0111..1 when a[MSB] = 0 and 1000..0 when a[MSB] = 1.
REQ-029 In mode 10 with borrow = 1, rez SHALL be 0.
REQ-030 In all other cases, rez SHALL be the raw difference.
REQ-031 borrow and ovf SHALL report the raw arithmetic regardless of mode.
REQ-032 rez, borrow, ovf and zero SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-033 With STAGES = 1 the block SHALL behave as a single registered subtractor with the same handshake.

Reset
REQ-034 While rst_n = 0 at a clock edge, all stage valid bits and out_valid SHALL clear to 0.
REQ-035 While rst_n = 0 at a clock edge, rez SHALL clear to 0, borrow and ovf SHALL clear to 0, and zero SHALL clear to 1.
REQ-036 A reset asserted mid-operation SHALL discard all in-flight results; no stale result SHALL appear after rst_n rises.
REQ-037 in_ready SHALL be 1 in the first cycle after reset release (out_valid = 0).

Verification (WIDTH = 8, STAGES = 2 unless stated)
REQ-038 Scenario: a = 0x35, b = 0x12, mode = 00, out_ready = 1 -> two cycles later rez = 0x23, borrow = 0, ovf = 0, zero = 0.
REQ-039 Scenario: a = 0x10, b = 0x01 (borrow crosses the chunk boundary) -> rez = 0x0F, borrow = 0; a = 0x00, b = 0x01 -> rez = 0xFF, borrow = 1.
REQ-040 Scenario: a = 0x80, b = 0x01 with mode 00 / 01 / 10 -> rez = 0x7F / 0x80 / 0x7F, ovf = 1; a = 0x7F, b = 0xFF with mode 01 -> rez = 0x7F, ovf = 1.
REQ-041 Scenario: a = 0x05, b = 0x07, mode = 10 -> rez = 0x00, borrow = 1, zero = 1.
REQ-042 Scenario: back-to-back stream of 6 pairs, out_ready held 0 for 3 cycles mid-stream -> in_ready = 0 during the stall, outputs held stable, all 6 results delivered in order with none lost or duplicated.
REQ-043 Scenario: rst_n pulsed low for one cycle while 2 results are in flight -> out_valid = 0 afterwards, and only post-reset inputs emerge; repeat the whole bench with WIDTH = 16, STAGES = 4 and STAGES = 1.
